// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - shared key, opcode and state encodings for the calculator entry path
package calc_pkg;

   typedef enum logic [1:0] {
      KEY_DIGIT = 2'b00,
      KEY_OP    = 2'b01,
      KEY_EQ    = 2'b10,
      KEY_CLR   = 2'b11
   } key_t;

   typedef enum logic [1:0] {
      OP_ADD = 2'b00,
      OP_SUB = 2'b01,
      OP_MUL = 2'b10,
      OP_MOD = 2'b11
   } op_t;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_HAVE_A  = 3'd1,
      ST_HAVE_OP = 3'd2,
      ST_HAVE_B  = 3'd3,
      ST_EXEC    = 3'd4,
      ST_SHOW    = 3'd5
   } state_t;

   // A DW+1 result fits DW signed bits when its two top bits agree.
   function automatic logic fits_narrow(input logic [1:0] top_bits);
      return top_bits[1] == top_bits[0];
   endfunction

endpackage

// File: rtl/calc_timeout_ctr.sv
// rtl/calc_timeout_ctr.sv - down-counter that pulses expire after CYCLES uninterrupted run cycles
module calc_timeout_ctr #(
   parameter int CYCLES = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic run,
   output logic expire
);

   localparam int CW = (CYCLES > 1) ? $clog2(CYCLES) : 1;
   localparam logic [CW-1:0] LOAD = CW'(CYCLES - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   assign expire = run & ~clr & (cnt_q == '0);

   always_comb begin
      cnt_d = cnt_q;
      if (clr || expire)
         cnt_d = LOAD;
      else if (run)
         cnt_d = cnt_q - 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst)
         cnt_q <= LOAD;
      else
         cnt_q <= cnt_d;
   end

endmodule

// File: rtl/calc_entry_ctrl.sv
// rtl/calc_entry_ctrl.sv - key-driven operand/operator sequencer feeding the ALU and latching its result
module calc_entry_ctrl
   import calc_pkg::*;
#(
   parameter int DW          = 3,
   parameter int TIMEOUT_CYC = 1_000_000
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          key_valid,
   input  logic [1:0]    key_type,
   input  logic [DW-1:0] key_data,
   output logic          key_ready,
   output logic [DW-1:0] alu_a,
   output logic [DW-1:0] alu_b,
   output logic [1:0]    alu_s,
   input  logic [DW:0]   alu_r,
   input  logic          alu_sf,
   input  logic          alu_zf,
   input  logic          alu_dzf,
   output logic [DW:0]   res,
   output logic          res_sf,
   output logic          res_zf,
   output logic          res_dzf,
   output logic          res_valid,
   output logic          err_seq
);

   state_t        state_q, state_d;
   logic [DW-1:0] alu_a_q, alu_a_d;
   logic [DW-1:0] alu_b_q, alu_b_d;
   op_t           alu_s_q, alu_s_d;
   logic [DW:0]   res_q, res_d;
   logic          res_sf_q, res_sf_d;
   logic          res_zf_q, res_zf_d;
   logic          res_dzf_q, res_dzf_d;
   logic          res_valid_q, res_valid_d;
   logic          err_seq_q, err_seq_d;
   logic          key_ready_q, key_ready_d;

   logic   key_acc;
   logic   in_entry;
   logic   tmo_expire;
   key_t   kt;
   op_t    key_op;
   logic   chain_ok;

   assign key_acc  = key_valid & key_ready_q;
   assign kt       = key_t'(key_type);
   assign key_op   = op_t'(key_data[1:0]);
   assign in_entry = (state_q == ST_HAVE_A) || (state_q == ST_HAVE_OP) || (state_q == ST_HAVE_B);
   assign chain_ok = ~res_dzf_q & fits_narrow(res_q[DW:DW-1]);

   calc_timeout_ctr #(
      .CYCLES (TIMEOUT_CYC)
   ) u_timeout (
      .clk    (clk),
      .rst    (rst),
      .clr    (key_acc | ~in_entry),
      .run    (in_entry),
      .expire (tmo_expire)
   );

   always_comb begin
      state_d   = state_q;
      alu_a_d   = alu_a_q;
      alu_b_d   = alu_b_q;
      alu_s_d   = alu_s_q;
      res_d     = res_q;
      res_sf_d  = res_sf_q;
      res_zf_d  = res_zf_q;
      res_dzf_d = res_dzf_q;
      err_seq_d = 1'b0;

      // expire already excludes a same-cycle key, so a late key keeps the entry alive
      if ((key_acc && kt == KEY_CLR) || tmo_expire) begin
         state_d   = ST_IDLE;
         alu_a_d   = '0;
         alu_b_d   = '0;
         alu_s_d   = OP_ADD;
         res_d     = '0;
         res_sf_d  = 1'b0;
         res_zf_d  = 1'b0;
         res_dzf_d = 1'b0;
      end else if (state_q == ST_EXEC) begin
         res_d     = alu_r;
         res_sf_d  = alu_sf;
         res_zf_d  = alu_zf;
         res_dzf_d = alu_dzf;
         state_d   = ST_SHOW;
      end else if (key_acc) begin
         case (state_q)
            ST_IDLE: begin
               if (kt == KEY_DIGIT) begin
                  alu_a_d = key_data;
                  state_d = ST_HAVE_A;
               end else
                  err_seq_d = 1'b1;
            end
            ST_HAVE_A: begin
               if (kt == KEY_DIGIT)
                  alu_a_d = key_data;
               else if (kt == KEY_OP) begin
                  alu_s_d = key_op;
                  state_d = ST_HAVE_OP;
               end else
                  err_seq_d = 1'b1;
            end
            ST_HAVE_OP: begin
               if (kt == KEY_OP)
                  alu_s_d = key_op;
               else if (kt == KEY_DIGIT) begin
                  alu_b_d = key_data;
                  state_d = ST_HAVE_B;
               end else
                  err_seq_d = 1'b1;
            end
            ST_HAVE_B: begin
               if (kt == KEY_DIGIT)
                  alu_b_d = key_data;
               else if (kt == KEY_EQ)
                  state_d = ST_EXEC;
               else
                  err_seq_d = 1'b1;
            end
            ST_SHOW: begin
               if (kt == KEY_DIGIT) begin
                  alu_a_d = key_data;
                  state_d = ST_HAVE_A;
               end else if (kt == KEY_OP && chain_ok) begin
                  alu_a_d = res_q[DW-1:0];
                  alu_s_d = key_op;
                  state_d = ST_HAVE_OP;
               end else
                  err_seq_d = 1'b1;
            end
            default: ;
         endcase
      end

      res_valid_d = (state_d == ST_SHOW);
      key_ready_d = (state_d != ST_EXEC);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         alu_a_q     <= '0;
         alu_b_q     <= '0;
         alu_s_q     <= OP_ADD;
         res_q       <= '0;
         res_sf_q    <= 1'b0;
         res_zf_q    <= 1'b0;
         res_dzf_q   <= 1'b0;
         res_valid_q <= 1'b0;
         err_seq_q   <= 1'b0;
         key_ready_q <= 1'b1;
      end else begin
         state_q     <= state_d;
         alu_a_q     <= alu_a_d;
         alu_b_q     <= alu_b_d;
         alu_s_q     <= alu_s_d;
         res_q       <= res_d;
         res_sf_q    <= res_sf_d;
         res_zf_q    <= res_zf_d;
         res_dzf_q   <= res_dzf_d;
         res_valid_q <= res_valid_d;
         err_seq_q   <= err_seq_d;
         key_ready_q <= key_ready_d;
      end
   end

   assign key_ready = key_ready_q;
   assign alu_a     = alu_a_q;
   assign alu_b     = alu_b_q;
   assign alu_s     = alu_s_q;
   assign res       = res_q;
   assign res_sf    = res_sf_q;
   assign res_zf    = res_zf_q;
   assign res_dzf   = res_dzf_q;
   assign res_valid = res_valid_q;
   assign err_seq   = err_seq_q;

endmodule

// File: tb/tb_calc_entry_ctrl.sv
// tb/tb_calc_entry_ctrl.sv - directed bench for calc_entry_ctrl with a behavioural 3-bit ALU
module tb_calc_entry_ctrl;
   import calc_pkg::*;

   localparam int DW = 3;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          key_valid = 1'b0;
   logic [1:0]    key_type = 2'b00;
   logic [DW-1:0] key_data = '0;
   logic          key_ready;
   logic [DW-1:0] alu_a, alu_b;
   logic [1:0]    alu_s;
   logic [DW:0]   alu_r;
   logic          alu_sf, alu_zf, alu_dzf;
   logic [DW:0]   res;
   logic          res_sf, res_zf, res_dzf, res_valid, err_seq;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   calc_entry_ctrl #(.DW(DW), .TIMEOUT_CYC(16)) dut (
      .clk(clk), .rst(rst), .key_valid(key_valid), .key_type(key_type), .key_data(key_data),
      .key_ready(key_ready), .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s),
      .alu_r(alu_r), .alu_sf(alu_sf), .alu_zf(alu_zf), .alu_dzf(alu_dzf),
      .res(res), .res_sf(res_sf), .res_zf(res_zf), .res_dzf(res_dzf),
      .res_valid(res_valid), .err_seq(err_seq)
   );

   // Behavioural ALU: signed add/sub/mul/mod, truncated to DW+1 bits
   logic signed [DW:0] ax, bx;
   always_comb begin
      ax      = {alu_a[DW-1], alu_a};
      bx      = {alu_b[DW-1], alu_b};
      alu_dzf = 1'b0;
      alu_r   = '0;
      case (alu_s)
         2'b00: alu_r = ax + bx;
         2'b01: alu_r = ax - bx;
         2'b10: alu_r = ax * bx;
         default: begin
            if (bx == 0) alu_dzf = 1'b1;
            else         alu_r = ax % bx;
         end
      endcase
      alu_sf = alu_r[DW];
      alu_zf = (alu_r == '0) & ~alu_dzf;
   end

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic press(input logic [1:0] t, input logic [DW-1:0] d);
      key_valid = 1'b1;
      key_type  = t;
      key_data  = d;
      @(negedge clk);
      key_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if ({alu_a, alu_b, alu_s, res} !== 12'h000) begin
         errors++; $display("FAIL reset_regs got %b exp 0", {alu_a, alu_b, alu_s, res});
      end
      checks++;
      if ({res_sf, res_zf, res_dzf, res_valid, err_seq, key_ready} !== 6'b000001) begin
         errors++; $display("FAIL reset_flags got %b exp 000001", {res_sf, res_zf, res_dzf, res_valid, err_seq, key_ready});
      end
   endtask

   task automatic test_basic_add();
      do_reset();
      press(KEY_DIGIT, 3'b001);
      press(KEY_OP, 3'b000);
      press(KEY_DIGIT, 3'b001);
      checks++;
      if ({alu_a, alu_b, alu_s} !== 8'b001_001_00) begin
         errors++; $display("FAIL basic_operands got %b exp 00100100", {alu_a, alu_b, alu_s});
      end
      press(KEY_EQ, 3'b000);
      checks++;
      if ({key_ready, res_valid} !== 2'b00) begin
         errors++; $display("FAIL exec_ready got %b exp 00", {key_ready, res_valid});
      end
      idle(1);
      checks++;
      if ({res, res_valid, res_sf, res_zf, res_dzf, key_ready} !== 9'b0010_1000_1) begin
         errors++; $display("FAIL basic_result got %b exp 001010001", {res, res_valid, res_sf, res_zf, res_dzf, key_ready});
      end
   endtask

   task automatic test_seq_errors();
      do_reset();
      press(KEY_EQ, 3'b000);
      checks++;
      if (err_seq !== 1'b1) begin errors++; $display("FAIL idle_eq_err got %b exp 1", err_seq); end
      press(KEY_OP, 3'b001);
      checks++;
      if (err_seq !== 1'b1) begin errors++; $display("FAIL idle_op_err got %b exp 1", err_seq); end
      idle(1);
      checks++;
      if ({err_seq, alu_a, alu_b, alu_s} !== 9'b0) begin
         errors++; $display("FAIL idle_unchanged got %b exp 0", {err_seq, alu_a, alu_b, alu_s});
      end
      press(KEY_DIGIT, 3'b001);
      press(KEY_OP, 3'b010);
      press(KEY_DIGIT, 3'b010);
      press(KEY_OP, 3'b000);
      checks++;
      if ({err_seq, alu_s} !== 3'b1_10) begin
         errors++; $display("FAIL haveb_op_err got %b exp 110", {err_seq, alu_s});
      end
      press(KEY_EQ, 3'b000);
      idle(1);
      checks++;
      if ({res, res_valid} !== 5'b0010_1) begin
         errors++; $display("FAIL haveb_kept_mul got %b exp 00101", {res, res_valid});
      end
   endtask

   task automatic test_chain();
      do_reset();
      press(KEY_DIGIT, 3'b001);
      press(KEY_OP, 3'b000);
      press(KEY_DIGIT, 3'b001);
      press(KEY_EQ, 3'b000);
      idle(1);
      press(KEY_OP, 3'b010);
      checks++;
      if ({alu_a, alu_s, res_valid, err_seq} !== 7'b010_10_00) begin
         errors++; $display("FAIL chain_load got %b exp 0101000", {alu_a, alu_s, res_valid, err_seq});
      end
      press(KEY_DIGIT, 3'b011);
      press(KEY_EQ, 3'b000);
      idle(1);
      checks++;
      if ({alu_a, res, res_valid} !== 8'b010_0110_1) begin
         errors++; $display("FAIL chain_mul got %b exp 01001101", {alu_a, res, res_valid});
      end
      press(KEY_DIGIT, 3'b010);
      press(KEY_OP, 3'b000);
      press(KEY_DIGIT, 3'b011);
      press(KEY_EQ, 3'b000);
      idle(1);
      checks++;
      if ({res, res_valid} !== 5'b0101_1) begin
         errors++; $display("FAIL wide_sum got %b exp 01011", {res, res_valid});
      end
      press(KEY_OP, 3'b000);
      checks++;
      if ({err_seq, res_valid, alu_a} !== 5'b1_1_010) begin
         errors++; $display("FAIL overflow_chain got %b exp 11010", {err_seq, res_valid, alu_a});
      end
   endtask

   task automatic test_negative_chain();
      do_reset();
      press(KEY_DIGIT, 3'b001);
      press(KEY_OP, 3'b001);
      press(KEY_DIGIT, 3'b011);
      press(KEY_EQ, 3'b000);
      idle(1);
      checks++;
      if ({res, res_sf, res_zf} !== 6'b1110_10) begin
         errors++; $display("FAIL neg_sub got %b exp 111010", {res, res_sf, res_zf});
      end
      press(KEY_OP, 3'b000);
      checks++;
      if ({err_seq, alu_a, alu_s} !== 6'b0_110_00) begin
         errors++; $display("FAIL neg_chain got %b exp 011000", {err_seq, alu_a, alu_s});
      end
      press(KEY_DIGIT, 3'b010);
      press(KEY_EQ, 3'b000);
      idle(1);
      checks++;
      if ({res, res_sf, res_zf} !== 6'b0000_01) begin
         errors++; $display("FAIL zero_flag got %b exp 000001", {res, res_sf, res_zf});
      end
   endtask

   task automatic test_divzero();
      do_reset();
      press(KEY_DIGIT, 3'b001);
      press(KEY_OP, 3'b011);
      press(KEY_DIGIT, 3'b000);
      press(KEY_EQ, 3'b000);
      idle(1);
      checks++;
      if ({res_dzf, res_valid} !== 2'b11) begin
         errors++; $display("FAIL dz_flag got %b exp 11", {res_dzf, res_valid});
      end
      press(KEY_OP, 3'b000);
      checks++;
      if ({err_seq, res_valid} !== 2'b11) begin
         errors++; $display("FAIL dz_chain got %b exp 11", {err_seq, res_valid});
      end
   endtask

   task automatic test_timeout();
      do_reset();
      press(KEY_DIGIT, 3'b010);
      idle(15);
      checks++;
      if (alu_a !== 3'b010) begin errors++; $display("FAIL tmo_early got %b exp 010", alu_a); end
      idle(1);
      checks++;
      if (alu_a !== 3'b000) begin errors++; $display("FAIL tmo_abort got %b exp 000", alu_a); end
      press(KEY_OP, 3'b000);
      checks++;
      if (err_seq !== 1'b1) begin errors++; $display("FAIL tmo_idle got %b exp 1", err_seq); end

      do_reset();
      press(KEY_DIGIT, 3'b010);
      idle(14);
      press(KEY_DIGIT, 3'b001);
      idle(15);
      checks++;
      if (alu_a !== 3'b001) begin errors++; $display("FAIL tmo_restart got %b exp 001", alu_a); end
      idle(1);
      checks++;
      if (alu_a !== 3'b000) begin errors++; $display("FAIL tmo_restart_abort got %b exp 000", alu_a); end

      do_reset();
      press(KEY_DIGIT, 3'b010);
      idle(15);
      press(KEY_DIGIT, 3'b011);
      checks++;
      if (alu_a !== 3'b011) begin errors++; $display("FAIL tmo_key_wins got %b exp 011", alu_a); end
      press(KEY_OP, 3'b001);
      checks++;
      if ({err_seq, alu_s} !== 3'b0_01) begin
         errors++; $display("FAIL tmo_key_state got %b exp 001", {err_seq, alu_s});
      end
   endtask

   task automatic test_clear_and_rst();
      do_reset();
      press(KEY_DIGIT, 3'b001);
      press(KEY_OP, 3'b000);
      press(KEY_DIGIT, 3'b001);
      press(KEY_EQ, 3'b000);
      idle(1);
      press(KEY_DIGIT, 3'b001);
      press(KEY_OP, 3'b010);
      press(KEY_DIGIT, 3'b010);
      press(KEY_CLR, 3'b000);
      checks++;
      if ({alu_a, alu_b, alu_s, res, res_sf, res_zf, res_dzf, res_valid, err_seq, key_ready} !== 18'b1) begin
         errors++; $display("FAIL clear_all got %b exp 1", {alu_a, alu_b, alu_s, res, res_sf, res_zf, res_dzf, res_valid, err_seq, key_ready});
      end
      press(KEY_DIGIT, 3'b011);
      press(KEY_OP, 3'b000);
      press(KEY_DIGIT, 3'b011);
      press(KEY_EQ, 3'b000);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checks++;
      if ({alu_a, alu_b, alu_s, res, res_valid, key_ready} !== 14'b1) begin
         errors++; $display("FAIL rst_exec got %b exp 1", {alu_a, alu_b, alu_s, res, res_valid, key_ready});
      end
      idle(1);
      checks++;
      if ({res, res_valid} !== 5'b0) begin
         errors++; $display("FAIL rst_exec_after got %b exp 0", {res, res_valid});
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_basic_add();
      test_seq_errors();
      test_chain();
      test_negative_chain();
      test_divzero();
      test_timeout();
      test_clear_and_rst();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
